// File: rtl/data_sram_resp_if.sv
// Data-SRAM port between the CPU core (master) and its responder (slave).
// One request per cycle, no handshake; read data returns one cycle later.
interface data_sram_resp_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// Responder for the core's data-SRAM port: word RAM plus LED/switch/timer/num/scratch
// config registers, with registered one-cycle read data.
module data_sram_resp #(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] CONF_HI = 16'hBFAF
) (
  input  logic               clk,
  input  logic               resetn,
  data_sram_resp_if.slave    bus,
  input  logic [7:0]         switch_i,
  output logic [15:0]        led_o,
  output logic [31:0]        num_o
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0] mem [0:RAM_WORDS-1];

  logic [31:0] timer;
  logic [31:0] scratch;
  logic [31:0] rdata;

  logic              is_conf;
  logic              wr;
  logic [RAM_AW-1:0] ram_idx;
  logic [13:0]       off_word;
  logic              sel_led;
  logic              sel_timer;
  logic              sel_num;
  logic              sel_scratch;
  logic [31:0]       rd_word;
  logic [31:0]       ram_q;
  logic [31:0]       led_merged;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Byte offset bits [1:0] are ignored, so decode on the word offset only.
  assign is_conf     = (bus.sram_addr[31:16] == CONF_HI);
  assign off_word    = bus.sram_addr[15:2];
  assign wr          = bus.sram_en && (|bus.sram_wen);
  assign ram_idx     = bus.sram_addr[RAM_AW+1:2];
  assign sel_led     = is_conf && (off_word == 14'(16'hF000 >> 2));
  assign sel_timer   = is_conf && (off_word == 14'(16'hF008 >> 2));
  assign sel_num     = is_conf && (off_word == 14'(16'hF00C >> 2));
  assign sel_scratch = is_conf && (off_word == 14'(16'hF010 >> 2));
  assign ram_q       = mem[ram_idx];

  // LED is only 16 bits wide; byte lanes 2-3 are dropped.
  assign led_merged = merge_lanes({16'b0, led_o}, bus.sram_wdata, {2'b00, bus.sram_wen[1:0]});

  always_comb begin
    rd_word = '0;
    if (!is_conf) begin
      rd_word = ram_q;
    end else begin
      case (off_word)
        14'(16'hF000 >> 2): rd_word = {16'b0, led_o};
        14'(16'hF004 >> 2): rd_word = {24'b0, switch_i};
        14'(16'hF008 >> 2): rd_word = timer;
        14'(16'hF00C >> 2): rd_word = num_o;
        14'(16'hF010 >> 2): rd_word = scratch;
        default:            rd_word = '0;
      endcase
    end
  end

  // RAM has no reset; the read mux above samples the old word, giving read-first.
  always_ff @(posedge clk) begin
    if (wr && !is_conf) begin
      mem[ram_idx] <= merge_lanes(ram_q, bus.sram_wdata, bus.sram_wen);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata   <= '0;
      led_o   <= '0;
      num_o   <= '0;
      timer   <= '0;
      scratch <= '0;
    end else begin
      if (bus.sram_en) rdata <= rd_word;
      if (wr && sel_led) led_o <= led_merged[15:0];
      if (wr && sel_num) num_o <= merge_lanes(num_o, bus.sram_wdata, bus.sram_wen);
      if (wr && sel_scratch) scratch <= merge_lanes(scratch, bus.sram_wdata, bus.sram_wen);
      // A timer write replaces this cycle's increment.
      if (wr && sel_timer) timer <= merge_lanes(timer, bus.sram_wdata, bus.sram_wen);
      else                 timer <= timer + 32'd1;
    end
  end

  assign bus.sram_rdata = rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: directed requests push expectations,
// a monitor compares them one cycle later against rdata/led_o/num_o.
module tb_data_sram_resp;

  localparam int K_NONE  = -1;
  localparam int K_RDATA = 0;
  localparam int K_LED   = 1;
  localparam int K_NUM   = 2;

  localparam logic [31:0] A_LED     = 32'hBFAF_F000;
  localparam logic [31:0] A_SWITCH  = 32'hBFAF_F004;
  localparam logic [31:0] A_TIMER   = 32'hBFAF_F008;
  localparam logic [31:0] A_NUM     = 32'hBFAF_F00C;
  localparam logic [31:0] A_SCRATCH = 32'hBFAF_F010;
  localparam logic [31:0] A_HOLE    = 32'hBFAF_F020;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  switch_i = 8'h00;
  logic [15:0] led_o;
  logic [31:0] num_o;
  logic        chk_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];

  data_sram_resp_if bus ();

  data_sram_resp #(.RAM_AW(12), .CONF_HI(16'hBFAF)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus.slave),
    .switch_i (switch_i),
    .led_o    (led_o),
    .num_o    (num_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request for a cycle; optionally queue what should appear after the edge.
  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input int kind,
                               input logic [31:0] exp, input string name);
    bus.sram_en    = en;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    chk_req        = (kind != K_NONE);
    if (kind != K_NONE) begin
      exp_q.push_back(exp);
      kind_q.push_back(kind);
      name_q.push_back(name);
    end
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  initial begin : monitor
    logic [31:0] e;
    int          k;
    string       n;
    forever begin
      @(posedge clk);
      if (chk_req && resetn) begin
        #1;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
          e = exp_q.pop_front();
          k = kind_q.pop_front();
          n = name_q.pop_front();
          case (k)
            K_LED:   checkOutput(n, {16'b0, led_o}, e);
            K_NUM:   checkOutput(n, num_o, e);
            default: checkOutput(n, bus.sram_rdata, e);
          endcase
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'h0;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_rdata", bus.sram_rdata, 32'h0);
    checkOutput("reset_led", {16'b0, led_o}, 32'h0);
    checkOutput("reset_num", num_o, 32'h0);

    resetn = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0, K_RDATA, 32'h0000_0004, "timer_5th_edge");

    applyStimulus(1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0, K_RDATA, 32'h11BB_33DD, "ram_byte_write");

    applyStimulus(1'b0, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF, K_RDATA, 32'h11BB_33DD, "hold_1");
    applyStimulus(1'b0, 4'h3, 32'h0000_0080, 32'h0000_0000, K_RDATA, 32'h11BB_33DD, "hold_2");
    applyStimulus(1'b0, 4'hC, 32'h0000_0044, 32'h5A5A_5A5A, K_RDATA, 32'h11BB_33DD, "hold_3");
    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0, K_RDATA, 32'h11BB_33DD, "hold_mem_intact");

    applyStimulus(1'b1, 4'hF, 32'h0000_0080, 32'h0000_0001, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'hF, 32'h0000_0080, 32'h0000_0002, K_RDATA, 32'h0000_0001, "read_first_old");
    applyStimulus(1'b1, 4'h0, 32'h0000_0080, 32'h0, K_RDATA, 32'h0000_0002, "read_first_new");

    applyStimulus(1'b1, 4'hF, A_LED, 32'hFFFF_1234, K_LED, 32'h0000_1234, "led_write");
    applyStimulus(1'b1, 4'hC, A_LED, 32'h5555_AAAA, K_LED, 32'h0000_1234, "led_upper_lanes");
    applyStimulus(1'b1, 4'h0, A_LED, 32'h0, K_RDATA, 32'h0000_1234, "led_read");
    switch_i = 8'hA5;
    applyStimulus(1'b1, 4'h0, A_SWITCH, 32'h0, K_RDATA, 32'h0000_00A5, "switch_read");
    applyStimulus(1'b1, 4'hF, A_SWITCH, 32'hFFFF_FFFF, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'h0, A_SWITCH, 32'h0, K_RDATA, 32'h0000_00A5, "switch_ro");
    applyStimulus(1'b1, 4'hF, A_HOLE, 32'hCAFE_BABE, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'h0, A_HOLE, 32'h0, K_RDATA, 32'h0000_0000, "unmapped_read");

    applyStimulus(1'b1, 4'hF, A_NUM, 32'hDEAD_BEEF, K_NUM, 32'hDEAD_BEEF, "num_write");
    applyStimulus(1'b1, 4'h0, A_NUM, 32'h0, K_RDATA, 32'hDEAD_BEEF, "num_read");
    applyStimulus(1'b1, 4'hC, A_SCRATCH, 32'h0BAD_F00D, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'h0, A_SCRATCH, 32'h0, K_RDATA, 32'h0BAD_0000, "scratch_partial");

    applyStimulus(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0, K_RDATA, 32'hFFFF_FFFE, "timer_load");
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0, K_RDATA, 32'hFFFF_FFFF, "timer_max");
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0, K_RDATA, 32'h0000_0000, "timer_wrap");
    applyStimulus(1'b1, 4'hF, A_TIMER, 32'h1234_5678, K_NONE, 32'h0, "");
    applyStimulus(1'b1, 4'b0001, A_TIMER, 32'h0000_0000, K_RDATA, 32'h1234_5678, "timer_pre_edge");
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0, K_RDATA, 32'h1234_5600, "timer_partial");

    applyStimulus(1'b1, 4'h0, 32'h0000_4040, 32'h0, K_RDATA, 32'h11BB_33DD, "ram_alias");

    // Reset mid-cycle while a read is being presented.
    bus.sram_en   = 1'b1;
    bus.sram_wen  = 4'h0;
    bus.sram_addr = 32'h0000_0080;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_rdata", bus.sram_rdata, 32'h0);
    checkOutput("midreset_led", {16'b0, led_o}, 32'h0);
    checkOutput("midreset_num", num_o, 32'h0);
    bus.sram_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0, K_RDATA, 32'h11BB_33DD, "ram_retained");
    applyStimulus(1'b1, 4'h0, A_SCRATCH, 32'h0, K_RDATA, 32'h0000_0000, "scratch_reset");
    applyStimulus(1'b1, 4'h0, A_LED, 32'h0, K_RDATA, 32'h0000_0000, "led_reset_read");

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, K_NONE, 32'h0, "");
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, K_NONE, 32'h0, "");
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the CPU data-SRAM port. It accepts the core's enable, byte-write-enable, address and write-data strobes, and serves them from an internal word-addressed RAM or from a small block of configuration registers: LED, switch, timer, numeric display and scratch. Read data is registered with one-cycle latency, matching the synchronous-SRAM contract the core's pipeline expects on `readdata`. It sits beside the core in the SoC top, wired directly to the `data_sram_*` outputs and `data_sram_rdata` input.

## Interface
Parameters:
- `RAM_AW`, 12: RAM word-address width (2^RAM_AW words, 16 KB default).
- `CONF_HI`, 16'hBFAF: value of `sram_addr[31:16]` that selects the config region.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `sram_en`  in  1  request valid this cycle.
- `sram_wen`  in  4  byte write enables; bit i writes `sram_wdata[8i+7:8i]`.
- `sram_addr`  in  32  byte address; bits [1:0] are ignored.
- `sram_wdata`  in  32  write data.
- `sram_rdata`  out  32  read data, registered.
- `switch_i`  in  8  board switches, sampled combinationally on read.
- `led_o`  out  16  LED register.
- `num_o`  out  32  numeric-display register.

## Operation
- Region select: config when `sram_addr[31:16]==CONF_HI`; otherwise RAM.
- RAM word index is `sram_addr[RAM_AW+1:2]`. Higher bits alias, with no error.
- Config offsets, using `sram_addr[15:0]`:
  - 16'hF000 LED: RW, low 16 bits.
  - 16'hF004 SWITCH: RO, `{24'b0, switch_i}`.
  - 16'hF008 TIMER: RW, 32 bits.
  - 16'hF00C NUM: RW, 32 bits.
  - 16'hF010 SCRATCH: RW, 32 bits.
  - Any other config offset reads 0 and ignores writes.
- Write: `sram_en && |sram_wen`. Only the enabled byte lanes of the target are updated. Lanes beyond a register's width are dropped (LED bytes 2–3, SWITCH entirely).
- Read: every `sram_en` cycle captures the addressed word into `sram_rdata`, including write cycles. The RAM is read-first: a read-during-write to the same address returns the old word.
- `sram_en=0`: no write, and `sram_rdata` holds its previous value.
- TIMER increments by 1 every cycle, wrapping 32'hFFFF_FFFF→0.
  - On a TIMER write cycle, the written byte lanes load `sram_wdata` and the unwritten lanes keep the current value.
  - No increment occurs on a TIMER write cycle.
  - A TIMER read returns the pre-edge value.
- RAM contents are not reset. Registers are reset.

## Timing
- Reset (`resetn=0`, asynchronous) forces:
  - `sram_rdata`=0, `led_o`=0, `num_o`=0.
  - TIMER=0, SCRATCH=0.
- Release of reset is synchronous to `clk`; TIMER reads 1 after the first rising edge.
- Read latency is exactly 1 cycle: a request at edge N drives `sram_rdata` valid after edge N, usable for the whole cycle N→N+1.
- Write latency is 1 cycle: state is updated at edge N. A read at edge N+1 sees the new value, so back-to-back write then read is supported with no bubble.
- `led_o`/`num_o` are register outputs and change only at the edge that writes them.
- One request per cycle, with no stall or handshake. The responder never back-pressures.
- Reset asserted mid-stream: an in-flight read is discarded and `sram_rdata` goes to 0 immediately. RAM retains any completed write.

## Test plan
- Reset: assert `resetn=0` mid-cycle → `sram_rdata`, `led_o`, `num_o` = 0 before the next edge. Release reset, then read TIMER at the 5th edge → 32'h4.
- RAM byte write: write 32'h11223344 wen=4'hF to 0x0000_0040, then 32'hAABBCCDD wen=4'b0101 → read returns 32'h11BB33DD one cycle later.
- Read-first collision: preload 0x80 with 32'h1, then issue a write of 32'h2 with a simultaneous read at the same address → rdata=32'h1. The next read → 32'h2.
- Config: write 32'hFFFF_1234 to BFAF_F000 → `led_o`=16'h1234. Set `switch_i`=8'hA5 and read BFAF_F004 → 32'h0000_00A5. A write to F004 changes nothing. Read BFAF_F020 → 0.
- Timer wrap/load: write TIMER=32'hFFFF_FFFE → reads 32'hFFFF_FFFE at the next edge, then 32'hFFFF_FFFF, then 0. A partial write wen=4'b0001 with 8'h00 clears only byte 0.
- Hold: after a read of 32'h11BB33DD, deassert `sram_en` for 3 cycles while `sram_addr`/`sram_wen` toggle → `sram_rdata` stays 32'h11BB33DD and memory is unchanged.
